// File: rtl/cnt_pkg.sv
// Shared definitions for the modulo up/down counter sequencer: command
// encoding, sequencer states and default sizing.
package cnt_pkg;

  localparam int W_DEF      = 4;
  localparam int MODMAX_DEF = 13;
  localparam int NW_DEF     = 8;

  localparam logic [1:0] OP_NOP  = 2'd0;
  localparam logic [1:0] OP_LOAD = 2'd1;
  localparam logic [1:0] OP_UP   = 2'd2;
  localparam logic [1:0] OP_DOWN = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_RUN  = 2'd2
  } state_t;

endpackage

// File: rtl/cnt_core.sv
// Modulo (MODMAX+1) up/down counter register. The wrap flag is combinational
// and marks a step that crosses the terminal value in either direction.
module cnt_core
  import cnt_pkg::*;
#(
  parameter int W      = W_DEF,
  parameter int MODMAX = MODMAX_DEF
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         step,
  input  logic         dir,   // 0 = up, 1 = down
  input  logic         load,
  input  logic [W-1:0] din,
  output logic [W-1:0] q,
  output logic         wrap
);

  localparam logic [W-1:0] TOP = W'(MODMAX);

  assign wrap = step && (dir ? (q == '0) : (q == TOP));

  // NOTE: sequential state is written only with non-blocking assignments so
  // every register samples the values that existed before the clock edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      q <= '0;
    end else if (load) begin
      q <= din;
    end else if (step) begin
      if (wrap)     q <= dir ? TOP : '0;
      else if (dir) q <= q - 1'b1;
      else          q <= q + 1'b1;
    end
  end

endmodule

// File: rtl/cnt_seq_ctrl.sv
// Command sequencer for the modulo counter: accepts LOAD/UP/DOWN/NOP over a
// valid/ready handshake, steps the core and reports completion and wraps.
module cnt_seq_ctrl
  import cnt_pkg::*;
#(
  parameter int W      = W_DEF,
  parameter int MODMAX = MODMAX_DEF,
  parameter int NW     = NW_DEF
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          cmd_valid,
  output logic          cmd_ready,
  input  logic [1:0]    cmd_op,
  input  logic [NW-1:0] cmd_arg,
  input  logic          pause,
  output logic [W-1:0]  cq,
  output logic          count,
  output logic          done,
  output logic          busy,
  output logic [NW-1:0] wrap_cnt
);

  state_t        state, state_nx;
  logic [NW-1:0] rem;      // step count in RUN, preset value in LOAD
  logic          dir_q;
  logic          accept;
  logic          step;
  logic          load;
  logic          done_set;
  logic          wrap;
  logic [W-1:0]  load_val;

  assign cmd_ready = (state == ST_IDLE);
  assign busy      = !cmd_ready;
  assign accept    = cmd_valid && cmd_ready;

  // The clamp looks at the full argument so that out-of-range presets
  // saturate at the terminal value instead of aliasing through the low bits.
  assign load_val = (rem > NW'(MODMAX)) ? W'(MODMAX) : rem[W-1:0];

  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nx;
  end

  // NOTE: every signal driven here gets a default first, so no path through
  // the case statement can leave one unassigned and infer a latch.
  always_comb begin
    state_nx = state;
    step     = 1'b0;
    load     = 1'b0;
    done_set = 1'b0;
    case (state)
      ST_IDLE: begin
        if (cmd_valid) state_nx = (cmd_op == OP_LOAD) ? ST_LOAD : ST_RUN;
      end
      ST_LOAD: begin
        load     = 1'b1;
        done_set = 1'b1;
        state_nx = ST_IDLE;
      end
      ST_RUN: begin
        if (!pause) begin
          if (rem != '0) begin
            step = 1'b1;
          end else begin
            done_set = 1'b1;
            state_nx = ST_IDLE;
          end
        end
      end
      default: state_nx = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rem      <= '0;
      dir_q    <= 1'b0;
      done     <= 1'b0;
      count    <= 1'b0;
      wrap_cnt <= '0;
    end else begin
      done  <= done_set;
      count <= wrap;
      if (accept) begin
        rem   <= (cmd_op == OP_NOP) ? '0 : cmd_arg;
        dir_q <= (cmd_op == OP_DOWN);
      end else if (step) begin
        rem <= rem - 1'b1;
      end
      if (wrap && (wrap_cnt != {NW{1'b1}})) wrap_cnt <= wrap_cnt + 1'b1;
    end
  end

  cnt_core #(
    .W      (W),
    .MODMAX (MODMAX)
  ) u_core (
    .clk  (clk),
    .rst  (rst),
    .step (step),
    .dir  (dir_q),
    .load (load),
    .din  (load_val),
    .q    (cq),
    .wrap (wrap)
  );

endmodule

// File: tb/tb_cnt_seq_ctrl.sv
// Self-checking bench for cnt_seq_ctrl: a per-edge behavioural model pushes
// expected outputs to a scoreboard queue, popped and compared after each edge.
module tb_cnt_seq_ctrl;
  import cnt_pkg::*;

  localparam int W      = 4;
  localparam int MODMAX = 13;
  localparam int NW     = 8;
  localparam int WMAX   = (1 << NW) - 1;

  logic          clk = 1'b0;
  logic          rst;
  logic          cmd_valid;
  logic          cmd_ready;
  logic [1:0]    cmd_op;
  logic [NW-1:0] cmd_arg;
  logic          pause;
  logic [W-1:0]  cq;
  logic          count;
  logic          done;
  logic          busy;
  logic [NW-1:0] wrap_cnt;

  typedef struct packed {
    logic [W-1:0]  cq;
    logic          count;
    logic          done;
    logic          busy;
    logic [NW-1:0] wrap_cnt;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  int   m_cq   = 0;
  int   m_wrap = 0;

  always #5 clk = ~clk;

  cnt_seq_ctrl #(.W(W), .MODMAX(MODMAX), .NW(NW)) dut (
    .clk       (clk),
    .rst       (rst),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_op    (cmd_op),
    .cmd_arg   (cmd_arg),
    .pause     (pause),
    .cq        (cq),
    .count     (count),
    .done      (done),
    .busy      (busy),
    .wrap_cnt  (wrap_cnt)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic push_exp(input int e_cq, input bit e_count, input bit e_done, input bit e_busy);
    exp_t e;
    e.cq       = W'(e_cq);
    e.count    = e_count;
    e.done     = e_done;
    e.busy     = e_busy;
    e.wrap_cnt = NW'(m_wrap);
    sb.push_back(e);
  endtask

  task automatic tick_check(input string tag);
    exp_t e;
    @(posedge clk);
    #1;
    check({tag, ".sb_depth"}, 32'(sb.size()), 32'd1);
    if (sb.size() != 0) begin
      e = sb.pop_front();
      check({tag, ".cq"},        32'(cq),        32'(e.cq));
      check({tag, ".count"},     32'(count),     32'(e.count));
      check({tag, ".done"},      32'(done),      32'(e.done));
      check({tag, ".busy"},      32'(busy),      32'(e.busy));
      check({tag, ".cmd_ready"}, 32'(cmd_ready), 32'(!e.busy));
      check({tag, ".wrap_cnt"},  32'(wrap_cnt),  32'(e.wrap_cnt));
    end
  endtask

  task automatic idle(input int n, input string tag);
    cmd_valid = 1'b0;
    pause     = 1'b0;
    for (int i = 0; i < n; i++) begin
      push_exp(m_cq, 1'b0, 1'b0, 1'b0);
      tick_check(tag);
    end
  endtask

  // Drives one command starting just after an edge. pmask bit k pauses edge
  // E(k); hold keeps cmd_valid high while busy; abort_at>0 resets at that edge.
  task automatic run_cmd(input logic [1:0] op, input int arg, input logic [63:0] pmask,
                         input bit hold, input int abort_at, input string name);
    int rem;
    bit down;
    bit fin;
    bit wr;
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_arg   = NW'(arg);
    pause     = 1'b0;
    push_exp(m_cq, 1'b0, 1'b0, 1'b1);
    tick_check({name, "/E0"});
    cmd_valid = hold;
    cmd_arg   = ~NW'(arg);
    if (op == OP_LOAD) begin
      m_cq = (arg > MODMAX) ? MODMAX : arg;
      push_exp(m_cq, 1'b0, 1'b1, 1'b0);
      tick_check({name, "/E1"});
    end else begin
      rem  = (op == OP_UP || op == OP_DOWN) ? arg : 0;
      down = (op == OP_DOWN);
      fin  = 1'b0;
      for (int k = 1; k < 400 && !fin; k++) begin
        pause = (k < 64) ? pmask[k] : 1'b0;
        if (k == abort_at) begin
          rst    = 1'b1;
          m_cq   = 0;
          m_wrap = 0;
          push_exp(0, 1'b0, 1'b0, 1'b0);
          tick_check({name, "/abort"});
          rst = 1'b0;
          fin = 1'b1;
        end else if (pause) begin
          push_exp(m_cq, 1'b0, 1'b0, 1'b1);
          tick_check({name, "/pause"});
        end else if (rem > 0) begin
          wr = 1'b0;
          if (!down) begin
            if (m_cq == MODMAX) begin m_cq = 0; wr = 1'b1; end
            else m_cq = m_cq + 1;
          end else begin
            if (m_cq == 0) begin m_cq = MODMAX; wr = 1'b1; end
            else m_cq = m_cq - 1;
          end
          if (wr && m_wrap < WMAX) m_wrap = m_wrap + 1;
          rem = rem - 1;
          push_exp(m_cq, wr, 1'b0, 1'b1);
          tick_check({name, "/step"});
        end else begin
          push_exp(m_cq, 1'b0, 1'b1, 1'b0);
          tick_check({name, "/done"});
          fin = 1'b1;
        end
      end
    end
    cmd_valid = 1'b0;
    pause     = 1'b0;
  endtask

  initial begin
    rst       = 1'b1;
    cmd_valid = 1'b0;
    cmd_op    = OP_NOP;
    cmd_arg   = '0;
    pause     = 1'b0;
    push_exp(0, 1'b0, 1'b0, 1'b0);
    tick_check("reset0");
    cmd_valid = 1'b1;
    cmd_op    = OP_UP;
    cmd_arg   = NW'(3);
    push_exp(0, 1'b0, 1'b0, 1'b0);
    tick_check("reset1");
    rst = 1'b0;
    idle(2, "post_reset");

    run_cmd(OP_LOAD, 9, '0, 1'b0, 0, "load9");
    idle(1, "gap");

    run_cmd(OP_LOAD, 11, '0, 1'b0, 0, "load11");
    idle(1, "gap");
    run_cmd(OP_UP, 5, '0, 1'b0, 0, "up5");
    idle(1, "gap");

    run_cmd(OP_LOAD, 1, '0, 1'b0, 0, "load1");
    idle(1, "gap");
    run_cmd(OP_DOWN, 3, '0, 1'b0, 0, "down3");
    idle(1, "gap");

    run_cmd(OP_LOAD, 20, '0, 1'b0, 0, "load20");
    idle(1, "gap");

    run_cmd(OP_UP, 0, '0, 1'b1, 0, "up0_hold");
    idle(1, "gap");
    run_cmd(OP_NOP, 7, '0, 1'b1, 0, "nop_hold");
    idle(1, "gap");
    run_cmd(OP_DOWN, 5, '0, 1'b1, 0, "down5_hold");
    idle(1, "gap");

    run_cmd(OP_LOAD, 2, '0, 1'b0, 0, "load2");
    idle(1, "gap");
    run_cmd(OP_UP, 4, 64'h0000_0000_0000_000C, 1'b0, 0, "up4_pause");
    idle(1, "gap");

    run_cmd(OP_DOWN, 2, '0, 1'b0, 0, "down2_b2b");
    run_cmd(OP_LOAD, 5, '0, 1'b0, 0, "load5_b2b");
    run_cmd(OP_UP, 9, '0, 1'b0, 0, "up9_b2b");
    idle(1, "gap");

    run_cmd(OP_UP, 10, '0, 1'b0, 4, "up10_abort");
    idle(2, "after_abort");
    run_cmd(OP_LOAD, 3, '0, 1'b0, 0, "load3");
    idle(1, "gap");
    run_cmd(OP_UP, 2, '0, 1'b0, 0, "up2");
    idle(1, "gap");

    for (int i = 0; i < 15; i++) begin
      run_cmd(OP_UP, 255, '0, 1'b0, 0, "up255_sat");
    end
    run_cmd(OP_DOWN, 30, '0, 1'b0, 0, "down30_sat");
    idle(2, "final");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
